// File: rtl/packet_generator.sv
`timescale 1ns/1ps
// Ethernet-style frame source: one request in, frame out as 64-bit valid/data/keep/last
// beats under ready backpressure, followed by a programmable inter-frame gap.
module packet_generator #(
  parameter int unsigned GENERATOR_ID    = 0,
  parameter int unsigned MAX_FRAME_BYTES = 1518,
  parameter int unsigned MIN_FRAME_BYTES = 14,
  parameter int unsigned IFG_CYCLES      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_length,
  input  logic [47:0] req_dst_mac,
  input  logic [47:0] req_src_mac,
  input  logic [15:0] req_ethertype,
  input  logic [7:0]  req_seed,
  output logic        req_error,
  output logic        packet_valid,
  output logic [63:0] packet_data,
  output logic [7:0]  packet_keep,
  output logic        packet_last,
  input  logic        packet_ready,
  output logic        busy,
  output logic [31:0] frames_sent,
  output logic [31:0] bytes_sent
);

  localparam int unsigned GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;

  state_e             state_q;
  logic [47:0]        dst_q;
  logic [47:0]        src_q;
  logic [15:0]        eth_q;
  logic [7:0]         seed_q;
  logic [15:0]        len_q;
  logic [15:0]        base_q;
  logic [15:0]        base_d;
  logic [GAP_W-1:0]   gap_q;
  logic               valid_q;
  logic [63:0]        data_q;
  logic [7:0]         keep_q;
  logic               last_q;
  logic               err_q;
  logic               busy_q;
  logic [31:0]        frames_q;
  logic [31:0]        bytes_q;
  logic               len_bad;
  logic               handshake;
  logic               unused_id;

  // Byte n of the frame: dst MAC, src MAC, ethertype (big-endian), then seeded ramp.
  function automatic logic [7:0] frame_byte(input logic [47:0] dst, input logic [47:0] src,
                                            input logic [15:0] eth, input logic [7:0] seed,
                                            input logic [15:0] n);
    logic [7:0] b;
    logic [2:0] idx;
    idx = 3'(n - 16'd6);
    if (n < 16'd6)        b = dst[{n[2:0], 3'b000} +: 8];
    else if (n < 16'd12)  b = src[{idx, 3'b000} +: 8];
    else if (n == 16'd12) b = eth[15:8];
    else if (n == 16'd13) b = eth[7:0];
    else                  b = seed + 8'(n - 16'd14);
    return b;
  endfunction

  function automatic logic [63:0] beat_data(input logic [47:0] dst, input logic [47:0] src,
                                            input logic [15:0] eth, input logic [7:0] seed,
                                            input logic [15:0] len, input logic [15:0] base);
    logic [63:0] d;
    logic [15:0] n;
    d = '0;
    for (int k = 0; k < 8; k++) begin
      n = base + 16'(k);
      if (n < len) d[8*k +: 8] = frame_byte(dst, src, eth, seed, n);
    end
    return d;
  endfunction

  function automatic logic [7:0] beat_keep(input logic [15:0] len, input logic [15:0] base);
    logic [7:0] kp;
    kp = '0;
    for (int k = 0; k < 8; k++) kp[k] = (base + 16'(k)) < len;
    return kp;
  endfunction

  function automatic logic beat_last(input logic [15:0] len, input logic [15:0] base);
    return ({1'b0, base} + 17'd8) >= {1'b0, len};
  endfunction

  assign unused_id = ^32'(GENERATOR_ID);
  assign len_bad   = (req_length < 16'(MIN_FRAME_BYTES)) || (req_length > 16'(MAX_FRAME_BYTES));
  assign handshake = valid_q && packet_ready;
  assign base_d    = base_q + 16'd8;

  assign req_ready    = (state_q == IDLE) && enable;
  assign req_error    = err_q;
  assign packet_valid = valid_q;
  assign packet_data  = data_q;
  assign packet_keep  = keep_q;
  assign packet_last  = last_q;
  assign busy         = busy_q;
  assign frames_sent  = frames_q;
  assign bytes_sent   = bytes_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      dst_q    <= '0;
      src_q    <= '0;
      eth_q    <= '0;
      seed_q   <= '0;
      len_q    <= '0;
      base_q   <= '0;
      gap_q    <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      keep_q   <= '0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      frames_q <= '0;
      bytes_q  <= '0;
    end else begin
      err_q <= 1'b0;
      if (handshake) bytes_q <= bytes_q + 32'($countones(keep_q));

      unique case (state_q)
        IDLE: begin
          if (req_valid && req_ready) begin
            if (len_bad) begin
              err_q <= 1'b1;
            end else begin
              dst_q   <= req_dst_mac;
              src_q   <= req_src_mac;
              eth_q   <= req_ethertype;
              seed_q  <= req_seed;
              len_q   <= req_length;
              base_q  <= 16'd0;
              valid_q <= 1'b1;
              data_q  <= beat_data(req_dst_mac, req_src_mac, req_ethertype, req_seed,
                                   req_length, 16'd0);
              keep_q  <= beat_keep(req_length, 16'd0);
              last_q  <= beat_last(req_length, 16'd0);
              busy_q  <= 1'b1;
              state_q <= SEND;
            end
          end
        end

        SEND: begin
          if (handshake) begin
            if (last_q) begin
              frames_q <= frames_q + 32'd1;
              valid_q  <= 1'b0;
              data_q   <= '0;
              keep_q   <= '0;
              last_q   <= 1'b0;
              if (IFG_CYCLES == 0) begin
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end else begin
                gap_q   <= GAP_W'(IFG_CYCLES - 1);
                state_q <= GAP;
              end
            end else begin
              base_q <= base_d;
              data_q <= beat_data(dst_q, src_q, eth_q, seed_q, len_q, base_d);
              keep_q <= beat_keep(len_q, base_d);
              last_q <= beat_last(len_q, base_d);
            end
          end
        end

        // Count out the inter-frame gap; requests stay blocked until IDLE.
        GAP: begin
          if (gap_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_generator.sv
`timescale 1ns/1ps
// Bench for packet_generator: vector table plus scoreboard of expected beats,
// with hand-written sequences for backpressure, inter-frame gap and mid-frame reset.
module tb_packet_generator;

  localparam int unsigned IFG = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_length;
  logic [47:0] req_dst_mac;
  logic [47:0] req_src_mac;
  logic [15:0] req_ethertype;
  logic [7:0]  req_seed;
  logic        req_error;
  logic        packet_valid;
  logic [63:0] packet_data;
  logic [7:0]  packet_keep;
  logic        packet_last;
  logic        packet_ready;
  logic        busy;
  logic [31:0] frames_sent;
  logic [31:0] bytes_sent;

  always #5 clk = ~clk;

  packet_generator #(
    .GENERATOR_ID(0), .MAX_FRAME_BYTES(1518), .MIN_FRAME_BYTES(14), .IFG_CYCLES(IFG)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .req_valid(req_valid), .req_ready(req_ready), .req_length(req_length),
    .req_dst_mac(req_dst_mac), .req_src_mac(req_src_mac), .req_ethertype(req_ethertype),
    .req_seed(req_seed), .req_error(req_error),
    .packet_valid(packet_valid), .packet_data(packet_data), .packet_keep(packet_keep),
    .packet_last(packet_last), .packet_ready(packet_ready),
    .busy(busy), .frames_sent(frames_sent), .bytes_sent(bytes_sent)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  typedef struct {
    logic [15:0] len;
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] eth;
    logic [7:0]  seed;
    bit          toggle;
    bit          exp_err;
    int          exp_beats;
    logic [7:0]  exp_last_keep;
  } vec_t;

  beat_t       exp_q[$];
  vec_t        vecs[8];
  logic [7:0]  fb[0:2047];
  int          checks = 0;
  int          errors = 0;
  int          frame_beats = 0;
  int          last_frame_beats = 0;
  logic [7:0]  last_frame_keep = '0;
  int          frames_seen = 0;
  bit          rdy_toggle = 1'b0;
  bit          rdy_hold = 1'b1;
  logic [31:0] exp_frames = '0;
  logic [31:0] exp_bytes = '0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference frame built byte-by-byte, then cut into expected beats.
  task automatic model_push(input logic [15:0] len, input logic [47:0] dst, input logic [47:0] src,
                            input logic [15:0] eth, input logic [7:0] seed);
    int    nb;
    int    n;
    beat_t x;
    for (int i = 0; i < int'(len); i++) begin
      if (i < 6)        fb[i] = dst[8*i +: 8];
      else if (i < 12)  fb[i] = src[8*(i-6) +: 8];
      else if (i == 12) fb[i] = eth[15:8];
      else if (i == 13) fb[i] = eth[7:0];
      else              fb[i] = seed + 8'(i - 14);
    end
    nb = (int'(len) + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      x = '0;
      for (int k = 0; k < 8; k++) begin
        n = 8*b + k;
        if (n < int'(len)) begin
          x.data[8*k +: 8] = fb[n];
          x.keep[k] = 1'b1;
        end
      end
      x.last = (b == nb - 1);
      exp_q.push_back(x);
    end
  endtask

  task automatic monitor();
    bit    prev_stall = 1'b0;
    beat_t prev_beat = '0;
    beat_t x;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        frame_beats = 0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && packet_valid)
          check("stall_hold", 80'({packet_data, packet_keep, packet_last}), 80'(prev_beat));
        if (packet_valid && packet_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got data %0h with no beat expected", packet_data);
          end else begin
            x = exp_q.pop_front();
            check("beat", 80'({packet_data, packet_keep, packet_last}), 80'(x));
          end
          frame_beats++;
          if (packet_last) begin
            last_frame_beats = frame_beats;
            last_frame_keep  = packet_keep;
            frames_seen++;
            frame_beats = 0;
          end
        end
        prev_stall = packet_valid && !packet_ready;
        prev_beat  = {packet_data, packet_keep, packet_last};
      end
    end
  endtask

  task automatic ready_driver();
    forever begin
      @(posedge clk);
      #1;
      if (rdy_toggle) packet_ready = !packet_ready;
      else            packet_ready = rdy_hold;
    end
  endtask

  // Hold the request until accepted; bad lengths must produce a single req_error pulse.
  task automatic send_req(input logic [15:0] len, input logic [47:0] dst, input logic [47:0] src,
                          input logic [15:0] eth, input logic [7:0] seed);
    bit bad;
    bit accepted;
    bad = (len < 16'd14) || (len > 16'd1518);
    @(posedge clk);
    #1;
    req_length = len; req_dst_mac = dst; req_src_mac = src;
    req_ethertype = eth; req_seed = seed; req_valid = 1'b1;
    if (!bad) begin
      model_push(len, dst, src, eth, seed);
      exp_frames = exp_frames + 32'd1;
      exp_bytes  = exp_bytes + 32'(len);
    end
    accepted = 1'b0;
    for (int i = 0; i < 400 && !accepted; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        #1;
        accepted = 1'b1;
      end
    end
    req_valid = 1'b0;
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL req_accept: request len %0d not accepted within 400 cycles", len);
    end else if (bad) begin
      check("req_error_pulse", 80'(req_error), 80'(1));
      check("no_valid_on_error", 80'(packet_valid), 80'(0));
      @(posedge clk);
      #1;
      check("req_error_clear", 80'(req_error), 80'(0));
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 5000 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && !packet_valid) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: %0d beats still expected, busy=%0b", exp_q.size(), busy);
    end
  endtask

  initial begin
    int base_frames;
    int rr;
    int vl;
    int n;
    bit found;

    rst = 1'b1; enable = 1'b0; req_valid = 1'b0; packet_ready = 1'b1;
    req_length = '0; req_dst_mac = '0; req_src_mac = '0; req_ethertype = '0; req_seed = '0;

    vecs[0] = '{16'd64,   48'h112233445566, 48'hA1A2A3A4A5A6, 16'h0800, 8'h00, 1'b0, 1'b0, 8,   8'hFF};
    vecs[1] = '{16'd61,   48'h0A0B0C0D0E0F, 48'h010203040506, 16'h86DD, 8'h00, 1'b0, 1'b0, 8,   8'h1F};
    vecs[2] = '{16'd13,   48'hDEADBEEF0001, 48'h000000000002, 16'h0800, 8'h11, 1'b0, 1'b1, 0,   8'h00};
    vecs[3] = '{16'd1519, 48'hDEADBEEF0003, 48'h000000000004, 16'h0800, 8'h22, 1'b0, 1'b1, 0,   8'h00};
    vecs[4] = '{16'd32,   48'hCAFEF00D1234, 48'h665544332211, 16'h88B5, 8'h7F, 1'b1, 1'b0, 4,   8'hFF};
    vecs[5] = '{16'd14,   48'hFFFFFFFFFFFF, 48'h123456789ABC, 16'h0806, 8'h55, 1'b0, 1'b0, 2,   8'h3F};
    vecs[6] = '{16'd15,   48'h020000000001, 48'h020000000002, 16'h0800, 8'hFE, 1'b1, 1'b0, 2,   8'h7F};
    vecs[7] = '{16'd1518, 48'h5A5A5A5A5A5A, 48'hA5A5A5A5A5A5, 16'h0800, 8'hF0, 1'b0, 1'b0, 190, 8'h3F};

    fork
      monitor();
      ready_driver();
    join_none

    // Reset state, with req_ready following enable even while in reset.
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready_dis", 80'(req_ready), 80'(0));
    check("rst_valid", 80'(packet_valid), 80'(0));
    check("rst_frames", 80'(frames_sent), 80'(0));
    check("rst_bytes", 80'(bytes_sent), 80'(0));
    check("rst_busy", 80'(busy), 80'(0));
    check("rst_req_error", 80'(req_error), 80'(0));
    enable = 1'b1;
    #1;
    check("rst_req_ready_en", 80'(req_ready), 80'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // enable low blocks acceptance of a pending request.
    enable = 1'b0;
    req_length = 16'd64; req_valid = 1'b1;
    repeat (4) @(negedge clk);
    check("disabled_req_ready", 80'(req_ready), 80'(0));
    check("disabled_no_valid", 80'(packet_valid), 80'(0));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    enable = 1'b1;

    foreach (vecs[i]) begin
      rdy_toggle  = vecs[i].toggle;
      base_frames = frames_seen;
      send_req(vecs[i].len, vecs[i].dst, vecs[i].src, vecs[i].eth, vecs[i].seed);
      wait_idle();
      check("frames_sent", 80'(frames_sent), 80'(exp_frames));
      check("bytes_sent", 80'(bytes_sent), 80'(exp_bytes));
      check("frames_seen", 80'(frames_seen), 80'(base_frames + (vecs[i].exp_err ? 0 : 1)));
      if (!vecs[i].exp_err) begin
        check("beat_count", 80'(last_frame_beats), 80'(vecs[i].exp_beats));
        check("last_keep", 80'(last_frame_keep), 80'(vecs[i].exp_last_keep));
      end
    end
    rdy_toggle = 1'b0;
    rdy_hold   = 1'b1;

    // Back-to-back frames: ready blocked for IFG cycles; valid low one more (accept latency).
    fork
      begin
        send_req(16'd64, 48'h111111111111, 48'h222222222222, 16'h0800, 8'h10);
        send_req(16'd64, 48'h333333333333, 48'h444444444444, 16'h0800, 8'h20);
      end
      begin
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
          @(negedge clk);
          if (packet_valid && packet_last && packet_ready) found = 1'b1;
        end
        rr = -1; vl = -1; n = 0;
        for (int i = 0; i < 50 && found && vl < 0; i++) begin
          @(negedge clk);
          n++;
          if (rr < 0 && req_ready) rr = n - 1;
          if (packet_valid) vl = n - 1;
        end
        check("ifg_ready_low", 80'(rr), 80'(IFG));
        check("ifg_valid_low", 80'(vl), 80'(IFG + 1));
      end
    join
    wait_idle();
    check("b2b_frames", 80'(frames_sent), 80'(exp_frames));
    check("b2b_bytes", 80'(bytes_sent), 80'(exp_bytes));

    // Reset while beat 3 of a 64-byte frame is on the bus.
    send_req(16'd64, 48'h0123456789AB, 48'hBA9876543210, 16'h0800, 8'h40);
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_valid", 80'(packet_valid), 80'(1));
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 80'(packet_valid), 80'(0));
    check("mid_rst_frames", 80'(frames_sent), 80'(0));
    check("mid_rst_bytes", 80'(bytes_sent), 80'(0));
    check("mid_rst_busy", 80'(busy), 80'(0));
    exp_frames = '0;
    exp_bytes  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    send_req(16'd64, 48'h0123456789AB, 48'hBA9876543210, 16'h0800, 8'h40);
    wait_idle();
    check("post_rst_frames", 80'(frames_sent), 80'(1));
    check("post_rst_bytes", 80'(bytes_sent), 80'(64));
    check("post_rst_beats", 80'(last_frame_beats), 80'(8));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
